lcd_result_writer: RTL
======================

Name: lcd_result_writer

Overview:
- Consumer end of the arithmetic-module result interface (16-bit result plus show strobe).
- Drives an HD44780-compatible 16x2 character LCD in 8-bit, write-only mode.
- On power-up: runs the LCD init sequence.
- On each new result request: converts the value to decimal and writes a 6-character field (sign plus 5 digits) at line 1, column 0.

Parameters:
POWERUP_CYCLES, 750000, wait after reset before the first command (15 ms at 50 MHz)
EN_CYCLES, 25, lcd_en high width per write (500 ns at 50 MHz)
CMD_WAIT_CYCLES, 2500, settle time after each non-clear write (50 us)
CLEAR_WAIT_CYCLES, 100000, settle time after the clear command 0x01 (2 ms)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high
value  input  16  result to display
value_valid  input  1  show request (level); connects to an arithmetic module's show_result
signed_mode  input  1  1 = interpret value as two's complement
busy  output  1  high while initialising, converting or writing
lcd_data  output  8  LCD DB7..DB0
lcd_rs  output  1  0 = command, 1 = character data
lcd_rw  output  1  constant 0
lcd_en  output  1  LCD enable strobe

Behaviour:
Reset values:
- busy=1, lcd_en=0, lcd_rs=0, lcd_data=0x00, lcd_rw=0.
- FSM state=POWERUP; pending=0; valid_d=0; shown_value=0.
- Reset asserted mid-write: lcd_en drops on the next edge and the init sequence restarts from POWERUP.

Write primitive (every LCD transfer):
- Cycle 0: set lcd_rs and lcd_data.
- Cycle 1: lcd_en rises and stays high EN_CYCLES cycles.
- lcd_en falls; data/rs are held for a further CMD_WAIT_CYCLES, or CLEAR_WAIT_CYCLES after 0x01.
- Then the next transfer starts.

FSM states:
- POWERUP: count POWERUP_CYCLES, then go to INIT.
- INIT: issue commands 0x38, 0x0C, 0x06, 0x01, in order, via the write primitive. Then go to IDLE.
- IDLE: busy=0. Go to CONVERT when req or pending is set.
- CONVERT: latch the value at entry (latest value wins).
  - Magnitude: if signed_mode=1 and value[15]=1, magnitude = ~value+1 and sign='-' (0x2D); otherwise magnitude = value and sign=' ' (0x20).
  - 0x8000 signed gives magnitude 32768 (unsigned 16-bit, no overflow).
  - Double-dabble, one shift per cycle: exactly 16 cycles to produce 5 BCD digits.
- SETADDR: write command 0x80.
- CHARS: write 6 characters: sign, then digits from ten-thousands to units as ASCII 0x30+d.
  - Leading zeros blank to 0x20; the units digit is always printed.
  - After the last character: shown_value := latched value, then return to IDLE.

Request rule:
- req = value_valid & (~valid_d | value != shown_value); valid_d is value_valid delayed by 1 cycle.
- A req while busy (including during POWERUP/INIT) sets pending. Pending is cleared on entry to CONVERT.
- Multiple reqs while busy collapse into one. The value used is whatever is present at CONVERT entry.
- value_valid held high with a constant value: exactly one update.
- value_valid low: no action. The displayed field is retained.

Busy and latency:
- busy is high in every state except IDLE.
- req in IDLE: CONVERT is entered on the next edge.
- Total update time = 1 + 16 + 7 × (2 + EN_CYCLES + CMD_WAIT_CYCLES) cycles.

Test Plan:
Bench parameters: POWERUP=10, EN=2, CMD_WAIT=4, CLEAR_WAIT=8.
1. Release reset -> no lcd_en for 10 cycles; then 4 strobes with rs=0 carrying 0x38, 0x0C, 0x06, 0x01; gap after 0x01 ≥8 cycles; busy falls afterwards.
2. value=0x04D2 (1234), signed_mode=0, value_valid pulse -> command 0x80, then chars 0x20,0x20,0x31,0x32,0x33,0x34 with rs=1; busy back low.
3. value=0xFFFB, signed_mode=1 -> chars '-',' ',' ',' ',' ','5' (0x2D,0x20,0x20,0x20,0x20,0x35). With signed_mode=0 -> ' ','6','5','5','3','1'.
4. value=0x8000 signed -> '-','3','2','7','6','8'. value=0x0000 -> 5 spaces, then '0'.
5. value_valid held high, value=7 -> exactly one update. Change value to 9 mid-write -> second update shows '9'. Changes 9->10->11 all while busy -> only one further update, showing 11.
6. Assert reset during CHARS -> lcd_en low next cycle, busy=1; full init sequence repeats before any character write.

Source files
------------

// File: rtl/lcd_result_writer.sv
// lcd_result_writer
// Takes a 16-bit result and shows it on an HD44780-compatible 16x2 LCD. The
// LCD is driven in 8-bit mode and is only ever written, never read. After
// power-up the block runs the LCD init sequence. Each new show request
// converts the value to decimal and writes a sign plus five digits at line 1,
// column 0.
module lcd_result_writer #(
    parameter int POWERUP_CYCLES    = 750000,
    parameter int EN_CYCLES         = 25,
    parameter int CMD_WAIT_CYCLES   = 2500,
    parameter int CLEAR_WAIT_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] value,
    input  logic        value_valid,
    input  logic        signed_mode,
    output logic        busy,
    output logic [7:0]  lcd_data,
    output logic        lcd_rs,
    output logic        lcd_rw,
    output logic        lcd_en
);

    localparam int CNT_W = 24;
    localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] PWR_LOAD   = CNT_W'(POWERUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] EN_LOAD    = CNT_W'(EN_CYCLES - 1);
    localparam logic [CNT_W-1:0] CMD_LOAD   = CNT_W'(CMD_WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CLR_LOAD   = CNT_W'(CLEAR_WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] SHIFT_LOAD = CNT_W'(15);

    typedef enum logic [2:0] {
        ST_POWERUP = 3'd0,
        ST_INIT    = 3'd1,
        ST_IDLE    = 3'd2,
        ST_CONVERT = 3'd3,
        ST_SETADDR = 3'd4,
        ST_CHARS   = 3'd5
    } state_t;

    // The phases of a single LCD transfer.
    typedef enum logic [1:0] {
        W_SETUP = 2'd0,
        W_EN    = 2'd1,
        W_HOLD  = 2'd2,
        W_DONE  = 2'd3
    } wphase_t;

    state_t            state_r, state_nxt_s;
    wphase_t           wphase_r, wphase_nxt_s;
    logic [CNT_W-1:0]  cnt_r, cnt_nxt_s;
    logic [2:0]        idx_r, idx_nxt_s;

    logic              load_s;
    logic              start_conv_s;
    logic              commit_s;
    logic              writing_s;
    logic              is_clear_s;
    logic [7:0]        byte_s;
    logic              rs_s;

    logic              valid_d_r;
    logic              pending_r;
    logic [15:0]       shown_value_r;
    logic [15:0]       latched_r;
    logic [19:0]       bcd_r;
    logic [15:0]       bin_r;
    logic [7:0]        sign_r;

    logic              neg_s;
    logic [15:0]       mag_s;
    logic [15:0]       cmp_s;
    logic              req_s;
    logic [35:0]       dd_s;

    // Does one double-dabble step. Each BCD digit of 5 or more gets 3 added,
    // and then the whole {bcd, bin} pair shifts left by one bit.
    function automatic logic [35:0] dd_step(input logic [19:0] bcd_in,
                                            input logic [15:0] bin_in);
        logic [19:0] adj;
        adj = bcd_in;
        for (int k = 0; k < 5; k++) begin
            if (adj[4*k +: 4] >= 4'd5) begin
                adj[4*k +: 4] = adj[4*k +: 4] + 4'd3;
            end else begin
                adj[4*k +: 4] = adj[4*k +: 4];
            end
        end
        return {adj[18:0], bin_in, 1'b0};
    endfunction

    // Returns the ASCII character at position pos of the 6-character field.
    // Position 0 is the sign. A leading zero is shown as a blank. The units
    // digit is always printed.
    function automatic logic [7:0] char_at(input logic [2:0]  pos,
                                           input logic [19:0] bcd,
                                           input logic [7:0]  sign);
        logic [7:0] c;
        case (pos)
            3'd0:    c = sign;
            3'd1:    c = (bcd[19:16] == 4'd0)  ? 8'h20 : {4'h3, bcd[19:16]};
            3'd2:    c = (bcd[19:12] == 8'd0)  ? 8'h20 : {4'h3, bcd[15:12]};
            3'd3:    c = (bcd[19:8]  == 12'd0) ? 8'h20 : {4'h3, bcd[11:8]};
            3'd4:    c = (bcd[19:4]  == 16'd0) ? 8'h20 : {4'h3, bcd[7:4]};
            default: c = {4'h3, bcd[3:0]};
        endcase
        return c;
    endfunction

    assign lcd_rw = 1'b0;

    // Compute the magnitude and detect a new request.
    always_comb begin
        neg_s = signed_mode & value[15];
        if (neg_s) begin
            mag_s = ~value + 16'd1;
        end else begin
            mag_s = value;
        end
        // While an update is running, compare against the value being written.
        // A steady input then does not queue a repeat of the same update.
        if ((state_r == ST_CONVERT) || (state_r == ST_SETADDR) || (state_r == ST_CHARS)) begin
            cmp_s = latched_r;
        end else begin
            cmp_s = shown_value_r;
        end
        req_s = value_valid & (~valid_d_r | (value != cmp_s));
        dd_s  = dd_step(bcd_r, bin_r);
    end

    // Next-state logic for the main FSM and for the write engine.
    always_comb begin
        state_nxt_s  = state_r;
        wphase_nxt_s = wphase_r;
        cnt_nxt_s    = cnt_r;
        idx_nxt_s    = idx_r;
        load_s       = 1'b0;
        start_conv_s = 1'b0;
        commit_s     = 1'b0;
        writing_s    = (state_r == ST_INIT) || (state_r == ST_SETADDR) || (state_r == ST_CHARS);
        is_clear_s   = (state_r == ST_INIT) && (idx_r == 3'd3);

        if (writing_s) begin
            case (wphase_r)
                W_SETUP: begin
                    wphase_nxt_s = W_EN;
                    cnt_nxt_s    = EN_LOAD;
                end
                W_EN: begin
                    if (cnt_r == CNT_ZERO) begin
                        wphase_nxt_s = W_HOLD;
                        cnt_nxt_s    = is_clear_s ? CLR_LOAD : CMD_LOAD;
                    end else begin
                        cnt_nxt_s = cnt_r - CNT_ONE;
                    end
                end
                W_HOLD: begin
                    if (cnt_r == CNT_ZERO) begin
                        wphase_nxt_s = W_DONE;
                    end else begin
                        cnt_nxt_s = cnt_r - CNT_ONE;
                    end
                end
                default: wphase_nxt_s = W_DONE;
            endcase
        end else begin
            wphase_nxt_s = wphase_r;
        end

        case (state_r)
            ST_POWERUP: begin
                if (cnt_r == CNT_ZERO) begin
                    state_nxt_s  = ST_INIT;
                    idx_nxt_s    = 3'd0;
                    wphase_nxt_s = W_SETUP;
                    load_s       = 1'b1;
                end else begin
                    cnt_nxt_s = cnt_r - CNT_ONE;
                end
            end
            ST_INIT: begin
                if (wphase_r == W_DONE) begin
                    if (idx_r == 3'd3) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        idx_nxt_s    = idx_r + 3'd1;
                        wphase_nxt_s = W_SETUP;
                        load_s       = 1'b1;
                    end
                end else begin
                    state_nxt_s = ST_INIT;
                end
            end
            ST_IDLE: begin
                if (req_s || pending_r) begin
                    state_nxt_s  = ST_CONVERT;
                    cnt_nxt_s    = SHIFT_LOAD;
                    start_conv_s = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CONVERT: begin
                if (cnt_r == CNT_ZERO) begin
                    state_nxt_s  = ST_SETADDR;
                    wphase_nxt_s = W_SETUP;
                    load_s       = 1'b1;
                end else begin
                    cnt_nxt_s = cnt_r - CNT_ONE;
                end
            end
            ST_SETADDR: begin
                if (wphase_r == W_DONE) begin
                    state_nxt_s  = ST_CHARS;
                    idx_nxt_s    = 3'd0;
                    wphase_nxt_s = W_SETUP;
                    load_s       = 1'b1;
                end else begin
                    state_nxt_s = ST_SETADDR;
                end
            end
            ST_CHARS: begin
                if (wphase_r == W_DONE) begin
                    if (idx_r == 3'd5) begin
                        state_nxt_s = ST_IDLE;
                        commit_s    = 1'b1;
                    end else begin
                        idx_nxt_s    = idx_r + 3'd1;
                        wphase_nxt_s = W_SETUP;
                        load_s       = 1'b1;
                    end
                end else begin
                    state_nxt_s = ST_CHARS;
                end
            end
            default: begin
                state_nxt_s = ST_POWERUP;
                cnt_nxt_s   = PWR_LOAD;
            end
        endcase
    end

    // Select the byte and the RS value for the transfer that starts next.
    always_comb begin
        byte_s = 8'h00;
        rs_s   = 1'b0;
        case (state_nxt_s)
            ST_INIT: begin
                case (idx_nxt_s)
                    3'd0:    byte_s = 8'h38;
                    3'd1:    byte_s = 8'h0C;
                    3'd2:    byte_s = 8'h06;
                    default: byte_s = 8'h01;
                endcase
            end
            ST_SETADDR: byte_s = 8'h80;
            ST_CHARS: begin
                rs_s   = 1'b1;
                byte_s = char_at(idx_nxt_s, bcd_r, sign_r);
            end
            default: begin
                byte_s = 8'h00;
                rs_s   = 1'b0;
            end
        endcase
    end

    // Registers for the FSM state, the write phase, the counter and the index.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= ST_POWERUP;
            wphase_r <= W_DONE;
            cnt_r    <= PWR_LOAD;
            idx_r    <= 3'd0;
        end else begin
            state_r  <= state_nxt_s;
            wphase_r <= wphase_nxt_s;
            cnt_r    <= cnt_nxt_s;
            idx_r    <= idx_nxt_s;
        end
    end

    // Registered LCD and busy outputs. Data and RS are held until the next transfer.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy     <= 1'b1;
            lcd_en   <= 1'b0;
            lcd_rs   <= 1'b0;
            lcd_data <= 8'h00;
        end else begin
            busy   <= (state_nxt_s != ST_IDLE);
            lcd_en <= (wphase_nxt_s == W_EN);
            if (load_s) begin
                lcd_data <= byte_s;
                lcd_rs   <= rs_s;
            end else begin
                lcd_data <= lcd_data;
                lcd_rs   <= lcd_rs;
            end
        end
    end

    // Request bookkeeping. Requests that arrive while busy collapse into one
    // pending flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_d_r     <= 1'b0;
            pending_r     <= 1'b0;
            shown_value_r <= 16'h0000;
        end else begin
            valid_d_r <= value_valid;
            if (start_conv_s) begin
                pending_r <= 1'b0;
            end else if (req_s && (state_r != ST_IDLE)) begin
                pending_r <= 1'b1;
            end else begin
                pending_r <= pending_r;
            end
            if (commit_s) begin
                shown_value_r <= latched_r;
            end else begin
                shown_value_r <= shown_value_r;
            end
        end
    end

    // Binary to BCD conversion. The value is latched on entry, then shifted
    // once per cycle for 16 cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            latched_r <= 16'h0000;
            bcd_r     <= 20'h00000;
            bin_r     <= 16'h0000;
            sign_r    <= 8'h20;
        end else if (start_conv_s) begin
            latched_r <= value;
            bcd_r     <= 20'h00000;
            bin_r     <= mag_s;
            sign_r    <= neg_s ? 8'h2D : 8'h20;
        end else if (state_r == ST_CONVERT) begin
            bcd_r <= dd_s[35:16];
            bin_r <= dd_s[15:0];
        end else begin
            bcd_r <= bcd_r;
            bin_r <= bin_r;
        end
    end

endmodule
